// File: rtl/irig_gen.sv
// IRIG-B (B00x, DC level-shift) time-code generator with symbol mirror.
// Build with IRIG_AUTOINC_EN defined to advance the time by 1 s per frame.
module irig_gen #(
    parameter int TICKS_PER_MS = 100000,
    parameter int CNT_W        = 17
) (
    input  logic       clk,
    input  logic       hrd_rst,
    input  logic       ce,
    input  logic       en,
    input  logic       time_load,
    input  logic [6:0] sec_bcd,
    input  logic [6:0] min_bcd,
    input  logic [5:0] hr_bcd,
    input  logic [9:0] day_bcd,
    output logic       irig_out,
    output logic [2:0] sym,
    output logic       sym_valid,
    output logic [6:0] bit_idx,
    output logic       frame_start,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICKS_PER_MS - 1);
    localparam logic [2:0] SYM_MARK = 3'b111;
    localparam logic [2:0] SYM_ONE  = 3'b011;
    localparam logic [2:0] SYM_ZERO = 3'b001;

    state_t           state, state_d;
    logic [CNT_W-1:0] tick, tick_d;
    logic [3:0]       slot, slot_d;
    logic [6:0]       bit_d;
    logic             out_d, sv_d, fs_d, frame_ld;
    logic [2:0]       sym_d;
    logic [3:0]       pw;

    // time word layout: {day[29:20], hr[19:14], min[13:7], sec[6:0]}
    logic [29:0] time_in, shadow, frame, src;
    logic [99:0] fv;

    assign time_in = {day_bcd, hr_bcd, min_bcd, sec_bcd};
    assign src     = time_load ? time_in : shadow;
    assign busy    = (state != IDLE);

    function automatic logic is_mark(input logic [6:0] i);
        return (i == 7'd0) || ((i % 7'd10) == 7'd9);
    endfunction

    always_comb begin
        fv        = '0;
        fv[1+:4]  = frame[3:0];
        fv[6+:3]  = frame[6:4];
        fv[10+:4] = frame[10:7];
        fv[15+:3] = frame[13:11];
        fv[20+:4] = frame[17:14];
        fv[25+:2] = frame[19:18];
        fv[30+:4] = frame[23:20];
        fv[35+:4] = frame[27:24];
        fv[40+:2] = frame[29:28];
    end

    // high time of the current bit, in ms slots
    always_comb begin
        unique case (1'b1)
            sym == SYM_MARK: pw = 4'd8;
            sym == SYM_ONE:  pw = 4'd5;
            default:         pw = 4'd2;
        endcase
    end

`ifdef IRIG_AUTOINC_EN
    logic        fresh;
    logic [29:0] ld;

    function automatic logic [29:0] inc_time(input logic [29:0] t);
        logic [6:0] s, m;
        logic [5:0] h;
        logic [9:0] d;
        logic       cs, cm, ch;
        s  = t[6:0];
        m  = t[13:7];
        h  = t[19:14];
        d  = t[29:20];
        cs = (s == 7'h59);
        cm = cs && (m == 7'h59);
        ch = cm && (h == 6'h23);
        if (cs) s = '0;
        else if (s[3:0] == 4'h9) s = {s[6:4] + 3'd1, 4'h0};
        else s[3:0] = s[3:0] + 4'd1;
        if (cm) m = '0;
        else if (cs && m[3:0] == 4'h9) m = {m[6:4] + 3'd1, 4'h0};
        else if (cs) m[3:0] = m[3:0] + 4'd1;
        if (ch) h = '0;
        else if (cm && h[3:0] == 4'h9) h = {h[5:4] + 2'd1, 4'h0};
        else if (cm) h[3:0] = h[3:0] + 4'd1;
        if (ch) begin
            if (d == 10'h365) d = 10'h001;
            else if (d[3:0] != 4'h9) d[3:0] = d[3:0] + 4'd1;
            else if (d[7:4] != 4'h9) d = {d[9:8], d[7:4] + 4'd1, 4'h0};
            else d = {d[9:8] + 2'd1, 8'h00};
        end
        return {d, h, m, s};
    endfunction

    // a freshly loaded time goes out as-is; otherwise advance 1 s
    assign ld = (time_load || fresh) ? src : inc_time(src);

    always_ff @(posedge clk or posedge hrd_rst) begin
        if (hrd_rst) begin
            shadow <= '0;
            frame  <= '0;
            fresh  <= 1'b1;
        end else if (frame_ld) begin
            shadow <= ld;
            frame  <= ld;
            fresh  <= 1'b0;
        end else if (time_load) begin
            shadow <= time_in;
            fresh  <= 1'b1;
        end
    end
`else
    always_ff @(posedge clk or posedge hrd_rst) begin
        if (hrd_rst) begin
            shadow <= '0;
            frame  <= '0;
        end else begin
            if (time_load) shadow <= time_in;
            if (frame_ld)  frame  <= src;
        end
    end
`endif

    always_comb begin
        state_d  = state;
        tick_d   = tick;
        slot_d   = slot;
        bit_d    = bit_idx;
        out_d    = irig_out;
        sym_d    = sym;
        sv_d     = 1'b0;
        fs_d     = 1'b0;
        frame_ld = 1'b0;
        if (ce) begin
            unique case (state)
                IDLE: if (en) state_d = LOAD;
                LOAD: begin
                    state_d  = RUN;
                    frame_ld = 1'b1;
                    tick_d   = '0;
                    slot_d   = '0;
                    bit_d    = '0;
                    out_d    = 1'b1;
                    sym_d    = SYM_MARK;
                    sv_d     = 1'b1;
                    fs_d     = 1'b1;
                end
                RUN: begin
                    if (tick != TICK_LAST) begin
                        tick_d = tick + CNT_W'(1);
                    end else begin
                        tick_d = '0;
                        if (slot != 4'd9) begin
                            slot_d = slot + 4'd1;
                            out_d  = (slot_d < pw);
                        end else if (bit_idx == 7'd99) begin
                            slot_d  = '0;
                            bit_d   = '0;
                            out_d   = 1'b0;
                            state_d = en ? LOAD : IDLE;
                        end else begin
                            slot_d = '0;
                            bit_d  = bit_idx + 7'd1;
                            out_d  = 1'b1;
                            sv_d   = 1'b1;
                            sym_d  = is_mark(bit_d) ? SYM_MARK :
                                     fv[bit_d] ? SYM_ONE : SYM_ZERO;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge hrd_rst) begin
        if (hrd_rst) begin
            state       <= IDLE;
            tick        <= '0;
            slot        <= '0;
            bit_idx     <= '0;
            irig_out    <= 1'b0;
            sym         <= '0;
            sym_valid   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_d;
            tick        <= tick_d;
            slot        <= slot_d;
            bit_idx     <= bit_d;
            irig_out    <= out_d;
            sym         <= sym_d;
            sym_valid   <= sv_d;
            frame_start <= fs_d;
        end
    end

endmodule

// File: tb/tb_irig_gen.sv
// Scoreboard bench for irig_gen with 4 ticks per ms (40 clk per bit).
// Frame expectations are queued at stimulus time and popped per sym_valid.
module tb_irig_gen;

    localparam logic [2:0] M = 3'b111;
    localparam logic [2:0] O = 3'b011;
    localparam logic [2:0] Z = 3'b001;

    logic       clk = 1'b0;
    logic       hrd_rst, ce, en, time_load;
    logic [6:0] sec_bcd, min_bcd;
    logic [5:0] hr_bcd;
    logic [9:0] day_bcd;
    logic       irig_out, sym_valid, frame_start, busy;
    logic [2:0] sym;
    logic [6:0] bit_idx;

    irig_gen #(.TICKS_PER_MS(4), .CNT_W(3)) dut (
        .clk(clk), .hrd_rst(hrd_rst), .ce(ce), .en(en),
        .time_load(time_load), .sec_bcd(sec_bcd), .min_bcd(min_bcd),
        .hr_bcd(hr_bcd), .day_bcd(day_bcd), .irig_out(irig_out),
        .sym(sym), .sym_valid(sym_valid), .bit_idx(bit_idx),
        .frame_start(frame_start), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] sym;
        int         idx;
    } exp_t;

    exp_t       exp_q[$];
    logic [2:0] rx_sym[100];
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, req);
        end
    endtask

    function automatic int wid(input logic [2:0] s);
        if (s == M) return 32;
        if (s == O) return 20;
        return 8;
    endfunction

    task automatic push_frame(input logic [6:0] s, input logic [6:0] m,
                              input logic [5:0] h, input logic [9:0] d);
        logic [99:0] v;
        exp_t e;
        v = '0;
        for (int i = 0; i < 4; i++) v[1+i]  = s[i];
        for (int i = 0; i < 3; i++) v[6+i]  = s[4+i];
        for (int i = 0; i < 4; i++) v[10+i] = m[i];
        for (int i = 0; i < 3; i++) v[15+i] = m[4+i];
        for (int i = 0; i < 4; i++) v[20+i] = h[i];
        for (int i = 0; i < 2; i++) v[25+i] = h[4+i];
        for (int i = 0; i < 4; i++) v[30+i] = d[i];
        for (int i = 0; i < 4; i++) v[35+i] = d[4+i];
        for (int i = 0; i < 2; i++) v[40+i] = d[8+i];
        for (int b = 0; b < 100; b++) begin
            e.idx = b;
            e.sym = (b == 0 || b % 10 == 9) ? M : (v[b] ? O : Z);
            exp_q.push_back(e);
        end
    endtask

    task automatic load(input logic [6:0] s, input logic [6:0] m,
                        input logic [5:0] h, input logic [9:0] d);
        sec_bcd = s; min_bcd = m; hr_bcd = h; day_bcd = d;
        time_load = 1'b1;
        @(negedge clk);
        time_load = 1'b0;
    endtask

    task automatic wait_bit(input int idx);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(sym_valid && bit_idx == 7'(idx)) && n < 10000);
        chk($sformatf("wait_bit%0d", idx), int'(n < 10000), 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 10000) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle", int'(busy), 0);
    endtask

    task automatic hchk(input int b, input logic [2:0] s);
        chk($sformatf("rx_bit%0d", b), int'(rx_sym[b]), int'(s));
    endtask

    // monitor: pops one expected symbol per sym_valid, checks high width
    logic ce_s = 1'b0;
    always @(posedge clk) ce_s = ce;

    bit   pend = 0, have = 0;
    logic busy_q = 1'b0;
    int   hi = 0, want = 0, since = 0, nv = 0;
    exp_t e_m;

    always @(negedge clk) begin
        if (hrd_rst) begin
            pend = 0; have = 0; nv = 0; busy_q = 1'b0;
        end else begin
            if (ce_s) since++;
            if (pend && sym_valid) begin
                chk("high_width", hi, want);
                pend = 0;
            end else if (pend && irig_out) begin
                if (ce_s) hi++;
            end else if (pend) begin
                chk("high_width", hi, want);
                pend = 0;
            end
            if (sym_valid) begin
                if (frame_start && nv != 0) begin
                    chk("bits_per_frame", nv, 100);
                    nv = 0;
                end
                if (have && !frame_start) chk("bit_period", since, 40);
                since = 0; have = 1; nv++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_sym", 1, 0);
                end else begin
                    e_m = exp_q.pop_front();
                    chk("sym", int'(sym), int'(e_m.sym));
                    chk("bit_idx", int'(bit_idx), e_m.idx);
                    chk("frame_start", int'(frame_start), int'(e_m.idx == 0));
                    chk("rise", int'(irig_out), 1);
                    rx_sym[bit_idx] = sym;
                    want = wid(e_m.sym);
                    hi = 1; pend = 1;
                end
            end
            if (busy_q && !busy) begin
                chk("bits_per_frame", nv, 100);
                nv = 0; have = 0;
            end
            busy_q = busy;
        end
    end

    int quiet, ob, oo;

    initial begin
        hrd_rst = 1'b1; ce = 1'b1; en = 1'b0; time_load = 1'b0;
        sec_bcd = '0; min_bcd = '0; hr_bcd = '0; day_bcd = '0;
        repeat (3) @(negedge clk);
        chk("rst_irig", int'(irig_out), 0);
        chk("rst_sym", int'(sym), 0);
        chk("rst_valid", int'(sym_valid), 0);
        chk("rst_idx", int'(bit_idx), 0);
        chk("rst_fs", int'(frame_start), 0);
        chk("rst_busy", int'(busy), 0);
        hrd_rst = 1'b0;
        @(negedge clk);

        // frame 1: 12:34:56 day 123; new time loaded mid-frame for frame 2
        load(7'h56, 7'h34, 6'h12, 10'h123);
        push_frame(7'h56, 7'h34, 6'h12, 10'h123);
        en = 1'b1;
        wait_bit(30);
        load(7'h01, 7'h00, 6'h00, 10'h000);
        push_frame(7'h01, 7'h00, 6'h00, 10'h000);
        wait_bit(99);
        @(negedge clk);
        hchk(0, M);
        hchk(1, Z); hchk(2, O); hchk(3, O); hchk(4, Z);
        hchk(6, O); hchk(7, Z); hchk(8, O);
        hchk(10, Z); hchk(11, Z); hchk(12, O); hchk(13, Z);
        hchk(40, O); hchk(41, Z); hchk(99, M);

        // frame 2: clock-enable pause, then en dropped at bit 50
        wait_bit(20);
        repeat (3) @(negedge clk);
        ce = 1'b0;
        ob = int'(bit_idx); oo = int'(irig_out); quiet = 0;
        repeat (6) begin
            @(negedge clk);
            if (sym_valid) quiet++;
        end
        chk("ce_hold_idx", int'(bit_idx), ob);
        chk("ce_hold_out", int'(irig_out), oo);
        chk("ce_no_valid", quiet, 0);
        ce = 1'b1;
        wait_bit(50);
        en = 1'b0;
        wait_bit(99);
        @(negedge clk);
        hchk(1, O); hchk(2, Z); hchk(3, Z); hchk(4, Z);
        hchk(6, Z); hchk(7, Z); hchk(8, Z);
        wait_idle();
        quiet = 0;
        repeat (200) begin
            @(negedge clk);
            if (irig_out || sym_valid || busy) quiet++;
        end
        chk("idle_quiet", quiet, 0);

        // frame 3: aborted by reset at bit 45 slot 3
`ifdef IRIG_AUTOINC_EN
        push_frame(7'h02, 7'h00, 6'h00, 10'h000);
`else
        push_frame(7'h01, 7'h00, 6'h00, 10'h000);
`endif
        en = 1'b1;
        wait_bit(45);
        repeat (12) @(posedge clk);
        #2;
        chk("pre_rst_idx", int'(bit_idx), 45);
        hrd_rst = 1'b1;
        exp_q.delete();
        #1;
        chk("rst_async_out", int'(irig_out), 0);
        chk("rst_async_idx", int'(bit_idx), 0);
        en = 1'b0;
        repeat (2) @(negedge clk);
        hrd_rst = 1'b0;
        @(negedge clk);

        // frames 4 and 5: 23:59:59 day 365 rollover
        load(7'h59, 7'h59, 6'h23, 10'h365);
        push_frame(7'h59, 7'h59, 6'h23, 10'h365);
`ifdef IRIG_AUTOINC_EN
        push_frame(7'h00, 7'h00, 6'h00, 10'h001);
`else
        push_frame(7'h59, 7'h59, 6'h23, 10'h365);
`endif
        en = 1'b1;
        wait_bit(99);
        wait_bit(50);
        en = 1'b0;
        wait_bit(99);
        @(negedge clk);
`ifdef IRIG_AUTOINC_EN
        hchk(1, Z); hchk(4, Z); hchk(10, Z); hchk(20, Z);
        hchk(30, O); hchk(31, Z); hchk(32, Z); hchk(33, Z);
        hchk(40, Z); hchk(41, Z);
`else
        hchk(1, O); hchk(4, O); hchk(10, O); hchk(20, O);
        hchk(30, O); hchk(31, Z); hchk(32, O); hchk(33, Z);
        hchk(40, O); hchk(41, O);
`endif
        wait_idle();
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/irig_gen.md
Name: irig_gen

Overview:
- IRIG-B (B00x, DC level-shift) time-code generator: the transmit end of the IRIG link whose decoder consumes 3-bit symbols.
- Serialises a latched BCD time of day into a 100-bit, 1 s frame of pulse-width-coded bits on irig_out.
- Mirrors each bit as a symbol code (111 marker, 011 one, 001 zero) for loopback into the receiver.
- Sits beside the receiver in the vector-voltmeter timing path; used for self-test and as the local time source.

Parameters:
- TICKS_PER_MS, 100000, ce-qualified clk cycles per 1 ms; valid range >= 2.
- CNT_W, 17, width of the ms tick counter; must satisfy 2^CNT_W >= TICKS_PER_MS.

Ports:
- clk  in  1  system clock.
- hrd_rst  in  1  reset, asynchronous, active-high.
- ce  in  1  clock enable; all counters advance only when ce=1.
- en  in  1  transmit enable; sampled at frame boundaries.
- time_load  in  1  1-cycle strobe: capture the *_bcd inputs into the shadow register.
- sec_bcd  in  7  seconds BCD (tens[6:4], units[3:0]).
- min_bcd  in  7  minutes BCD.
- hr_bcd  in  6  hours BCD (tens[5:4]).
- day_bcd  in  10  day of year BCD (hundreds[9:8]).
- irig_out  out  1  coded IRIG-B level.
- sym  out  3  current bit symbol: 111 marker, 011 one, 001 zero.
- sym_valid  out  1  1-cycle pulse at the start of each bit.
- bit_idx  out  7  current bit 0..99.
- frame_start  out  1  1-cycle pulse at the start of bit 0.
- busy  out  1  high while a frame is in progress.

Behaviour:
- Reset values: irig_out=0, sym=000, sym_valid=0, bit_idx=0, frame_start=0, busy=0. Shadow and frame registers cleared; FSM in IDLE.
- FSM states and transitions:
  - IDLE: wait for en=1, then go to LOAD.
  - LOAD: copy shadow into the frame register (one clk), then go to RUN.
  - RUN: run bits 0..99. After the last tick of bit 99, go to LOAD if en=1, else IDLE.
- Timing counters, all advancing on ce only:
  - tick counter 0..TICKS_PER_MS-1.
  - ms slot 0..9 within a bit.
  - bit_idx 0..99, wrapping to 0 at frame end.
- Bit timing:
  - Each bit lasts 10 ms. irig_out is high from slot 0 for 2 ms (zero), 5 ms (one) or 8 ms (marker), then low for the rest of the bit.
  - irig_out is registered. It rises on the first RUN cycle of the bit, the same cycle sym_valid and sym update.
  - frame_start is asserted with sym_valid when bit_idx=0.
- Frame map:
  - Markers at bits 0, 9, 19, 29, 39, 49, 59, 69, 79, 89, 99.
  - Seconds: units at bits 1-4 (LSB first), tens at 6-8.
  - Minutes: units at 10-13, tens at 15-17.
  - Hours: units at 20-23, tens at 25-26.
  - Day: units at 30-33, tens at 35-38, hundreds at 40-41.
  - All other bits are zero.
- Time loading:
  - time_load updates the shadow at any time.
  - The frame register changes only in LOAD, so the frame being sent is never corrupted mid-frame.
  - If time_load and LOAD occur in the same cycle, LOAD takes the new inputs (bypass).
- en handling:
  - en deasserted mid-frame: the frame completes, then the FSM goes to IDLE and irig_out stays 0.
  - en re-asserted in IDLE: the first bit begins 1 clk after LOAD.
- busy is high in LOAD and RUN.
- ce=0: all state freezes, outputs hold, and sym_valid is not asserted.
- hrd_rst mid-frame: immediate return to reset values; the next frame restarts at bit 0.
- BCD inputs are not range-checked; illegal digits are transmitted as given.

Optional Feature:
- Macro IRIG_AUTOINC_EN.
- When defined:
  - In LOAD, if no time_load occurred since the previous LOAD, the shadow is incremented by 1 s before the copy.
  - Increment uses BCD carries: 59 s -> 00 s with a minute carry; 59 min -> 00; 23 h -> 00 with a day carry; day 365 -> 001.
  - The first LOAD after reset or time_load sends the loaded time unincremented.
- When undefined, the shadow holds; every frame repeats the last loaded time.

Test Plan:
- TICKS_PER_MS=4. Load 12:34:56 day 123, set en=1 -> bit 0 is a marker high for 32 clk. Bits 1-4 = 0,1,1,0 and bits 6-8 = 1,0,1 (sec 56). Minute units bits 10-13 = 0,0,1,0. Day hundreds bits 40-41 = 1,0.
- Pulse widths: any zero bit -> irig_out high 8 clk, low 32. Any one bit -> high 20, low 20. Bit 99 marker -> high 32, low 8. sym_valid shows exactly 100 pulses per frame with frame_start on the first.
- Drop en at bit 50 -> frame ends after bit 99 and busy falls. irig_out stays 0 for 200 clk. Re-assert en -> new frame_start.
- Pulse time_load with 00:00:01 at bit 30 -> current frame still shows the old seconds; the next frame shows sec bits 1-4 = 1,0,0,0.
- Assert hrd_rst at bit 45 slot 3 -> irig_out=0 and bit_idx=0 within the same cycle. After release, the frame starts from bit 0.
- With IRIG_AUTOINC_EN, load 23:59:59 day 365 and run two frames -> the second frame decodes 00:00:00 day 001. Without the macro, the second frame repeats 23:59:59 day 365.
